// File: rtl/button_counter.sv
// Two debounced push buttons driving an 8-bit up/down counter shown on LED0..LED7.
// Each button runs through a 2-flop synchronizer and a four-state stability debouncer.

module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 240000
) (
  input  logic clk,
  input  logic rst,
  input  logic sw,
  output logic press
);

  typedef enum logic [1:0] {
    RELEASED,
    WAIT_PRESS,
    PRESSED,
    WAIT_RELEASE
  } state_t;

  // The entry edge counts as the first stable sample, so the last one lands at D-1.
  localparam logic [19:0] LAST = 20'(DEBOUNCE_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_meta;
  logic        r_sync;
  logic [19:0] r_cnt;
  logic [19:0] w_cnt_nxt;
  logic        r_press;
  logic        w_press_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= sw;
      r_sync <= r_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RELEASED;
      r_cnt   <= 20'd0;
      r_press <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_press <= w_press_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = 20'd0;
    w_press_nxt = 1'b0;
    case (r_state)
      RELEASED: begin
        if (r_sync) begin
          w_state_nxt = WAIT_PRESS;
          w_cnt_nxt   = 20'd1;
        end
      end
      WAIT_PRESS: begin
        if (!r_sync) begin
          w_state_nxt = RELEASED;
        end else if (r_cnt == LAST) begin
          w_state_nxt = PRESSED;
          w_press_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 20'd1;
        end
      end
      PRESSED: begin
        if (!r_sync) begin
          w_state_nxt = WAIT_RELEASE;
          w_cnt_nxt   = 20'd1;
        end
      end
      WAIT_RELEASE: begin
        if (r_sync) begin
          w_state_nxt = PRESSED;
        end else if (r_cnt == LAST) begin
          w_state_nxt = RELEASED;
        end else begin
          w_cnt_nxt = r_cnt + 20'd1;
        end
      end
      default: w_state_nxt = RELEASED;
    endcase
  end

  assign press = r_press;

endmodule

module button_counter #(
  parameter int DEBOUNCE_CYCLES = 240000
) (
  input  logic clk,
  input  logic rst,
  input  logic SW1,
  input  logic SW2,
  output logic LED0,
  output logic LED1,
  output logic LED2,
  output logic LED3,
  output logic LED4,
  output logic LED5,
  output logic LED6,
  output logic LED7,
  output logic press1,
  output logic press2
);

  logic       w_press1;
  logic       w_press2;
  logic [7:0] r_count;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb1 (
    .clk   (clk),
    .rst   (rst),
    .sw    (SW1),
    .press (w_press1)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb2 (
    .clk   (clk),
    .rst   (rst),
    .sw    (SW2),
    .press (w_press2)
  );

  // Simultaneous strobes cancel; both directions wrap mod 256.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= 8'h00;
    end else if (w_press1 && !w_press2) begin
      r_count <= r_count + 8'd1;
    end else if (w_press2 && !w_press1) begin
      r_count <= r_count - 8'd1;
    end
  end

  assign press1 = w_press1;
  assign press2 = w_press2;
  assign LED0   = r_count[0];
  assign LED1   = r_count[1];
  assign LED2   = r_count[2];
  assign LED3   = r_count[3];
  assign LED4   = r_count[4];
  assign LED5   = r_count[5];
  assign LED6   = r_count[6];
  assign LED7   = r_count[7];

endmodule

// File: tb/tb_button_counter.sv
// Randomized and directed bench for button_counter against a stable-run reference model.

module tb_button_counter;

  localparam int D = 4;

  logic clk;
  logic clk_en;
  logic rst;
  logic SW1;
  logic SW2;
  logic LED0, LED1, LED2, LED3, LED4, LED5, LED6, LED7;
  logic press1;
  logic press2;
  logic [7:0] w_leds;

  int n_chk;
  int n_err;

  // Reference model: raw input delayed two edges, debounced level flips after D equal samples.
  bit m_meta[2];
  bit m_sync[2];
  bit m_deb[2];
  bit m_prs[2];
  int m_run[2];
  int m_cnt;

  int edge_no;
  int p1_first;
  int p1_cnt;
  int p2_first;
  int p2_cnt;
  int led_at7;

  button_counter #(.DEBOUNCE_CYCLES(D)) dut (
    .clk    (clk),
    .rst    (rst),
    .SW1    (SW1),
    .SW2    (SW2),
    .LED0   (LED0),
    .LED1   (LED1),
    .LED2   (LED2),
    .LED3   (LED3),
    .LED4   (LED4),
    .LED5   (LED5),
    .LED6   (LED6),
    .LED7   (LED7),
    .press1 (press1),
    .press2 (press2)
  );

  assign w_leds = {LED7, LED6, LED5, LED4, LED3, LED2, LED1, LED0};

  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clk_en) clk = ~clk;
    end
  end

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      m_meta[b] = 1'b0;
      m_sync[b] = 1'b0;
      m_deb[b]  = 1'b0;
      m_prs[b]  = 1'b0;
      m_run[b]  = 0;
    end
    m_cnt = 0;
  endtask

  task automatic model_edge(input bit r1, input bit r2);
    bit raw [2];
    bit nprs;
    raw[0] = r1;
    raw[1] = r2;
    if (m_prs[0] && !m_prs[1]) m_cnt = (m_cnt + 1) % 256;
    else if (m_prs[1] && !m_prs[0]) m_cnt = (m_cnt + 255) % 256;
    for (int b = 0; b < 2; b++) begin
      nprs = 1'b0;
      if (m_sync[b] != m_deb[b]) begin
        m_run[b]++;
        if (m_run[b] == D) begin
          m_deb[b] = m_sync[b];
          m_run[b] = 0;
          nprs     = m_deb[b];
        end
      end else begin
        m_run[b] = 0;
      end
      m_prs[b]  = nprs;
      m_sync[b] = m_meta[b];
      m_meta[b] = raw[b];
    end
  endtask

  task automatic check_outputs(input string where);
    chk_val({where, ".leds"}, 32'(w_leds), 32'(m_cnt));
    chk_val({where, ".press1"}, 32'(press1), 32'(m_prs[0]));
    chk_val({where, ".press2"}, 32'(press2), 32'(m_prs[1]));
  endtask

  task automatic clr_track();
    edge_no  = 0;
    p1_first = -1;
    p1_cnt   = 0;
    p2_first = -1;
    p2_cnt   = 0;
    led_at7  = -1;
  endtask

  // Called at a negedge; drives inputs, advances one rising edge, checks, returns at next negedge.
  task automatic cyc(input bit s1, input bit s2);
    SW1 = s1;
    SW2 = s2;
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge(s1, s2);
    #1;
    edge_no++;
    if (press1 === 1'b1) begin
      if (p1_cnt == 0) p1_first = edge_no;
      p1_cnt++;
    end
    if (press2 === 1'b1) begin
      if (p2_cnt == 0) p2_first = edge_no;
      p2_cnt++;
    end
    if (edge_no == 7) led_at7 = int'(w_leds);
    check_outputs("cyc");
    @(negedge clk);
  endtask

  task automatic rst_pulse(input bit s1, input bit s2, input int n);
    rst = 1'b1;
    model_reset();
    #1;
    check_outputs("rst_now");
    for (int i = 0; i < n; i++) cyc(s1, s2);
    rst = 1'b0;
  endtask

  task automatic press_btn(input bit s1, input bit s2);
    for (int i = 0; i < 8; i++) cyc(s1, s2);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0);
  endtask

  initial begin
    n_chk  = 0;
    n_err  = 0;
    clk_en = 1'b0;
    rst    = 1'b0;
    SW1    = 1'b0;
    SW2    = 1'b0;
    model_reset();
    clr_track();

    // Reset with the clock stopped must clear outputs immediately.
    #1 rst = 1'b1;
    #2;
    chk_val("rst_stopped.leds", 32'(w_leds), 32'h00);
    chk_val("rst_stopped.press1", 32'(press1), 32'h0);
    chk_val("rst_stopped.press2", 32'(press2), 32'h0);
    #10 rst = 1'b0;
    clk_en = 1'b1;
    @(negedge clk);

    // Held SW1: one strobe at edge 6, LEDs 0x01 at edge 7.
    clr_track();
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0);
    chk_val("hold.strobe_edge", 32'(p1_first), 32'd6);
    chk_val("hold.strobe_count", 32'(p1_cnt), 32'd1);
    chk_val("hold.led_edge7", 32'(led_at7), 32'h01);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0);
    chk_val("hold.after_release", 32'(w_leds), 32'h01);
    press_btn(1'b1, 1'b0);
    chk_val("hold.second_press", 32'(w_leds), 32'h02);

    // Glitch and bounce must not strobe.
    clr_track();
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0);
    for (int i = 0; i < 12; i++) cyc(1'(i % 2 == 0), 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0);
    chk_val("glitch.strobes", 32'(p1_cnt), 32'd0);
    chk_val("glitch.leds", 32'(w_leds), 32'h02);

    // Wrap in both directions.
    rst_pulse(1'b0, 1'b0, 1);
    press_btn(1'b0, 1'b1);
    chk_val("wrap.down", 32'(w_leds), 32'hFF);
    press_btn(1'b1, 1'b0);
    chk_val("wrap.up", 32'(w_leds), 32'h00);

    // Simultaneous presses cancel.
    for (int k = 0; k < 5; k++) press_btn(1'b1, 1'b0);
    chk_val("both.pre", 32'(w_leds), 32'h05);
    clr_track();
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1);
    chk_val("both.p1_edge", 32'(p1_first), 32'd6);
    chk_val("both.p2_edge", 32'(p2_first), 32'd6);
    chk_val("both.p1_count", 32'(p1_cnt), 32'd1);
    chk_val("both.leds", 32'(w_leds), 32'h05);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0);

    // Reset during WAIT_PRESS discards the press; a still-held button re-presses.
    rst_pulse(1'b0, 1'b0, 1);
    clr_track();
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0);
    chk_val("midrst.no_strobe", 32'(p1_cnt), 32'd0);
    rst_pulse(1'b1, 1'b0, 2);
    chk_val("midrst.leds", 32'(w_leds), 32'h00);
    clr_track();
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0);
    chk_val("midrst.strobe_edge", 32'(p1_first), 32'd6);
    chk_val("midrst.strobe_count", 32'(p1_cnt), 32'd1);
    chk_val("midrst.led_edge7", 32'(led_at7), 32'h01);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0);

    // Random segments with occasional resets, checked cycle by cycle.
    for (int seg = 0; seg < 300; seg++) begin
      bit s1;
      bit s2;
      int len;
      s1  = 1'($urandom_range(0, 1));
      s2  = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 10));
      if ($urandom_range(0, 39) == 0) rst_pulse(s1, s2, 1);
      for (int i = 0; i < len; i++) cyc(s1, s2);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
